// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// FSM state encoding, transaction owner, access width codes and defaults.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;

   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   // Clear the two byte-offset bits so the memory always sees a word address.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/mem_arbiter_be_gen.sv
// Byte-enable and write-lane replication for sub-word stores.
// Purely combinational; the arbiter registers the results on grant.
module mem_be_gen
   import mem_arbiter_pkg::*;
(
   input  logic [1:0]  width_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o
);

   // Select lanes from access width and byte offset; replicate store data onto every lane.
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = 32'h0000_0000;
      case (width_i)
         WIDTH_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         WIDTH_HALF: begin
            // Half-word accesses ignore addr[0]; only the upper/lower half is selected.
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            // Word (10) and the unused code 11 both mean a full word.
            be_o    = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory port.
// One transaction outstanding at a time; data has priority unless fetch has
// been stalled for STARVE_LIMIT cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   // instruction fetch port
   input  logic        i_valid_i,
   output logic        i_ready_o,
   input  logic [31:0] i_addr_i,
   output logic        i_rvalid_ro,
   output logic [31:0] i_rdata_ro,
   // data port
   input  logic        d_valid_i,
   output logic        d_ready_o,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   input  logic        d_write_i,
   input  logic [1:0]  d_width_i,
   output logic        d_rvalid_ro,
   output logic [31:0] d_rdata_ro,
   // memory port
   output logic        m_valid_ro,
   input  logic        m_ready_i,
   output logic [31:0] m_addr_ro,
   output logic [31:0] m_wdata_ro,
   output logic        m_write_ro,
   output logic [3:0]  m_be_ro,
   input  logic        m_rvalid_i,
   input  logic [31:0] m_rdata_i
);

   localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

   state_e      state_q;
   owner_e      owner_q;
   logic [3:0]  starve_q;
   logic [3:0]  starve_d;

   logic        m_valid_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wdata_q;
   logic        m_write_q;
   logic [3:0]  m_be_q;
   logic        i_rvalid_q;
   logic [31:0] i_rdata_q;
   logic        d_rvalid_q;
   logic [31:0] d_rdata_q;

   logic        fetch_pri_s;
   logic        grant_i_s;
   logic        grant_d_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_rep_s;

   mem_be_gen u_be_gen (
      .width_i   (d_width_i),
      .addr_lo_i (d_addr_i[1:0]),
      .wdata_i   (d_wdata_i),
      .be_o      (be_s),
      .wdata_o   (wdata_rep_s)
   );

   // Grants only exist in IDLE; the starved fetch overrides data priority.
   assign fetch_pri_s = i_valid_i && (starve_q == LIMIT);
   assign grant_d_s   = (state_q == ST_IDLE) && d_valid_i && !fetch_pri_s;
   assign grant_i_s   = (state_q == ST_IDLE) && i_valid_i && (fetch_pri_s || !d_valid_i);

   assign i_ready_o = grant_i_s;
   assign d_ready_o = grant_d_s;

   // Starvation counter: counts every cycle a fetch waits, saturates at the limit.
   always_comb begin
      starve_d = starve_q;
      if (!i_valid_i || grant_i_s) begin
         starve_d = 4'd0;
      end else if (starve_q != LIMIT) begin
         starve_d = starve_q + 4'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

   // Transaction FSM with registered memory request and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_FETCH;
         m_valid_q  <= 1'b0;
         m_addr_q   <= 32'h0000_0000;
         m_wdata_q  <= 32'h0000_0000;
         m_write_q  <= 1'b0;
         m_be_q     <= 4'b0000;
         i_rvalid_q <= 1'b0;
         i_rdata_q  <= 32'h0000_0000;
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= 32'h0000_0000;
      end else begin
         // Response pulses last exactly one cycle.
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_d_s) begin
                  owner_q   <= OWN_DATA;
                  m_valid_q <= 1'b1;
                  m_addr_q  <= word_align(d_addr_i);
                  m_wdata_q <= wdata_rep_s;
                  m_write_q <= d_write_i;
                  m_be_q    <= be_s;
                  state_q   <= ST_REQ;
               end else if (grant_i_s) begin
                  owner_q   <= OWN_FETCH;
                  m_valid_q <= 1'b1;
                  m_addr_q  <= word_align(i_addr_i);
                  m_wdata_q <= 32'h0000_0000;
                  m_write_q <= 1'b0;
                  m_be_q    <= 4'b1111;
                  state_q   <= ST_REQ;
               end else begin
                  state_q   <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (m_ready_i) begin
                  m_valid_q <= 1'b0;
                  // Stores need no response; reads wait for m_rvalid_i.
                  state_q   <= m_write_q ? ST_IDLE : ST_RESP;
               end else begin
                  state_q   <= ST_REQ;
               end
            end
            ST_RESP: begin
               if (m_rvalid_i) begin
                  if (owner_q == OWN_DATA) begin
                     d_rdata_q  <= m_rdata_i;
                     d_rvalid_q <= 1'b1;
                  end else begin
                     i_rdata_q  <= m_rdata_i;
                     i_rvalid_q <= 1'b1;
                  end
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_RESP;
               end
            end
            default: begin
               m_valid_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_valid_ro  = m_valid_q;
   assign m_addr_ro   = m_addr_q;
   assign m_wdata_ro  = m_wdata_q;
   assign m_write_ro  = m_write_q;
   assign m_be_ro     = m_be_q;
   assign i_rvalid_ro = i_rvalid_q;
   assign i_rdata_ro  = i_rdata_q;
   assign d_rvalid_ro = d_rvalid_q;
   assign d_rdata_ro  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_LIMIT = 4).
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_valid_i;
   logic        i_ready_o;
   logic [31:0] i_addr_i;
   logic        i_rvalid_ro;
   logic [31:0] i_rdata_ro;
   logic        d_valid_i;
   logic        d_ready_o;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic        d_write_i;
   logic [1:0]  d_width_i;
   logic        d_rvalid_ro;
   logic [31:0] d_rdata_ro;
   logic        m_valid_ro;
   logic        m_ready_i;
   logic [31:0] m_addr_ro;
   logic [31:0] m_wdata_ro;
   logic        m_write_ro;
   logic [3:0]  m_be_ro;
   logic        m_rvalid_i;
   logic [31:0] m_rdata_i;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid_i   (i_valid_i),
      .i_ready_o   (i_ready_o),
      .i_addr_i    (i_addr_i),
      .i_rvalid_ro (i_rvalid_ro),
      .i_rdata_ro  (i_rdata_ro),
      .d_valid_i   (d_valid_i),
      .d_ready_o   (d_ready_o),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_write_i   (d_write_i),
      .d_width_i   (d_width_i),
      .d_rvalid_ro (d_rvalid_ro),
      .d_rdata_ro  (d_rdata_ro),
      .m_valid_ro  (m_valid_ro),
      .m_ready_i   (m_ready_i),
      .m_addr_ro   (m_addr_ro),
      .m_wdata_ro  (m_wdata_ro),
      .m_write_ro  (m_write_ro),
      .m_be_ro     (m_be_ro),
      .m_rvalid_i  (m_rvalid_i),
      .m_rdata_i   (m_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue a store with immediate m_ready and check the registered request.
   task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] width, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      d_valid_i = 1'b1; d_write_i = 1'b1; d_addr_i = addr; d_wdata_i = wdata; d_width_i = width;
      #1;
      chk({tag, "_dready"}, {31'd0, d_ready_o}, 32'd1);
      tick();
      d_valid_i = 1'b0;
      chk({tag, "_mvalid"}, {31'd0, m_valid_ro}, 32'd1);
      chk({tag, "_maddr"},  m_addr_ro, exp_addr);
      chk({tag, "_mbe"},    {28'd0, m_be_ro}, {28'd0, exp_be});
      chk({tag, "_mwdata"}, m_wdata_ro, exp_wdata);
      chk({tag, "_mwrite"}, {31'd0, m_write_ro}, 32'd1);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      chk({tag, "_mvalid_drop"}, {31'd0, m_valid_ro}, 32'd0);
      chk({tag, "_no_rsp"}, {30'd0, i_rvalid_ro, d_rvalid_ro}, 32'd0);
      // Back in IDLE: a fresh fetch request is granted combinationally.
      i_valid_i = 1'b1;
      #1;
      chk({tag, "_idle_after"}, {31'd0, i_ready_o}, 32'd1);
      i_valid_i = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b0; i_valid_i = 1'b0; i_addr_i = 32'd0;
      d_valid_i = 1'b0; d_addr_i = 32'd0; d_wdata_i = 32'd0; d_write_i = 1'b0; d_width_i = 2'b00;
      m_ready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 32'd0;
      #1 rst = 1'b1;
      #1;
      // Reset state
      chk("rst_mvalid", {31'd0, m_valid_ro}, 32'd0);
      chk("rst_maddr",  m_addr_ro, 32'd0);
      chk("rst_mbe",    {28'd0, m_be_ro}, 32'd0);
      chk("rst_rvalid", {30'd0, i_rvalid_ro, d_rvalid_ro}, 32'd0);
      chk("rst_rdata",  i_rdata_ro | d_rdata_ro, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Lone fetch, granted in first cycle after reset
      i_valid_i = 1'b1; i_addr_i = 32'h0000_0100;
      #1;
      chk("f1_iready", {31'd0, i_ready_o}, 32'd1);
      chk("f1_dready", {31'd0, d_ready_o}, 32'd0);
      tick();
      i_valid_i = 1'b0;
      chk("f1_mvalid", {31'd0, m_valid_ro}, 32'd1);
      chk("f1_maddr",  m_addr_ro, 32'h0000_0100);
      chk("f1_mbe",    {28'd0, m_be_ro}, 32'h0000_000F);
      chk("f1_mwrite", {31'd0, m_write_ro}, 32'd0);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      chk("f1_mvalid_drop", {31'd0, m_valid_ro}, 32'd0);
      m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0013;
      tick();
      m_rvalid_i = 1'b0; m_rdata_i = 32'd0;
      chk("f1_irvalid", {31'd0, i_rvalid_ro}, 32'd1);
      chk("f1_irdata",  i_rdata_ro, 32'h0000_0013);
      chk("f1_drvalid", {31'd0, d_rvalid_ro}, 32'd0);
      tick();
      chk("f1_irvalid_once", {31'd0, i_rvalid_ro}, 32'd0);

      // Stores of each width
      do_store("sb", 32'h0000_0203, 32'h0000_00AB, 2'b00, 32'h0000_0200, 4'b1000, 32'hABAB_ABAB);
      do_store("sh", 32'h0000_0013, 32'h1234_5678, 2'b01, 32'h0000_0010, 4'b1100, 32'h5678_5678);
      do_store("sw", 32'h0000_0022, 32'hDEAD_BEEF, 2'b11, 32'h0000_0020, 4'b1111, 32'hDEAD_BEEF);

      // m_rvalid_i in IDLE is ignored
      m_rvalid_i = 1'b1; m_rdata_i = 32'h9999_9999;
      tick();
      m_rvalid_i = 1'b0;
      chk("idle_rvalid_ign", {30'd0, i_rvalid_ro, d_rvalid_ro}, 32'd0);

      // Simultaneous requests: data wins, then memory stalls 5 cycles
      i_valid_i = 1'b1; i_addr_i = 32'h0000_0400;
      d_valid_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h0000_0300;
      d_width_i = 2'b10; d_wdata_i = 32'h0000_0055;
      #1;
      chk("sim_dready", {31'd0, d_ready_o}, 32'd1);
      chk("sim_iready", {31'd0, i_ready_o}, 32'd0);
      tick();
      d_valid_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stall_mvalid", {31'd0, m_valid_ro}, 32'd1);
         chk("stall_maddr",  m_addr_ro, 32'h0000_0300);
         chk("stall_mbe",    {28'd0, m_be_ro}, 32'h0000_000F);
         chk("stall_mwdata", m_wdata_ro, 32'h0000_0055);
         chk("stall_iready", {31'd0, i_ready_o}, 32'd0);
         tick();
      end
      chk("stall_end_mvalid", {31'd0, m_valid_ro}, 32'd1);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFE_F00D;
      tick();
      m_rvalid_i = 1'b0;
      chk("ld_drvalid", {31'd0, d_rvalid_ro}, 32'd1);
      chk("ld_drdata",  d_rdata_ro, 32'hCAFE_F00D);
      chk("ld_irvalid", {31'd0, i_rvalid_ro}, 32'd0);
      // Fetch has waited long enough to beat a new data request
      d_valid_i = 1'b1;
      #1;
      chk("starved_iready", {31'd0, i_ready_o}, 32'd1);
      chk("starved_dready", {31'd0, d_ready_o}, 32'd0);
      tick();
      d_valid_i = 1'b0; i_valid_i = 1'b0;
      chk("ld_drvalid_once", {31'd0, d_rvalid_ro}, 32'd0);
      chk("f2_maddr", m_addr_ro, 32'h0000_0400);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      m_rvalid_i = 1'b1; m_rdata_i = 32'h1111_2222;
      tick();
      m_rvalid_i = 1'b0;
      chk("f2_irvalid", {31'd0, i_rvalid_ro}, 32'd1);
      chk("f2_irdata",  i_rdata_ro, 32'h1111_2222);
      chk("f2_drvalid", {31'd0, d_rvalid_ro}, 32'd0);
      tick();

      // Continuous store stream with a pending fetch (counter starts at 0)
      i_valid_i = 1'b1; i_addr_i = 32'h0000_0600;
      d_valid_i = 1'b1; d_write_i = 1'b1; d_addr_i = 32'h0000_0700;
      d_width_i = 2'b10; d_wdata_i = 32'h0000_0001;
      m_ready_i = 1'b1;
      #1;
      chk("st_a_dready", {31'd0, d_ready_o}, 32'd1);
      chk("st_a_iready", {31'd0, i_ready_o}, 32'd0);
      tick();
      chk("st_b_ready", {30'd0, i_ready_o, d_ready_o}, 32'd0);
      tick();
      chk("st_c_dready", {31'd0, d_ready_o}, 32'd1);
      chk("st_c_iready", {31'd0, i_ready_o}, 32'd0);
      tick();
      tick();
      chk("st_e_iready", {31'd0, i_ready_o}, 32'd1);
      chk("st_e_dready", {31'd0, d_ready_o}, 32'd0);
      tick();
      chk("st_f_maddr",  m_addr_ro, 32'h0000_0600);
      chk("st_f_mwrite", {31'd0, m_write_ro}, 32'd0);
      tick();
      m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0077;
      tick();
      m_rvalid_i = 1'b0;
      chk("st_f_irvalid", {31'd0, i_rvalid_ro}, 32'd1);
      chk("st_f_irdata",  i_rdata_ro, 32'h0000_0077);
      // Counter restarted from 0 on the fetch grant, so data wins again
      #1;
      chk("st_g_dready", {31'd0, d_ready_o}, 32'd1);
      chk("st_g_iready", {31'd0, i_ready_o}, 32'd0);
      d_valid_i = 1'b0; i_valid_i = 1'b0; m_ready_i = 1'b0;
      tick();

      // Reset while waiting for a load response
      d_valid_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h0000_0500;
      tick();
      d_valid_i = 1'b0;
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("rr_mvalid", {31'd0, m_valid_ro}, 32'd0);
      chk("rr_maddr",  m_addr_ro, 32'd0);
      chk("rr_mbe",    {28'd0, m_be_ro}, 32'd0);
      chk("rr_rdata",  i_rdata_ro | d_rdata_ro, 32'd0);
      tick();
      rst = 1'b0;
      m_rvalid_i = 1'b1; m_rdata_i = 32'h5A5A_5A5A;
      tick();
      m_rvalid_i = 1'b0;
      tick();
      chk("rr_no_pulse", {30'd0, i_rvalid_ro, d_rvalid_ro}, 32'd0);
      chk("rr_drdata",   d_rdata_ro, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
